// File: rtl/l2_arb_pkg.sv
// Shared constants and width helpers for the L2 request arbiter.
// Optional feature macro: L2_REQ_ARB_ERR_EN (sticky per-tile stray-response error).
package l2_arb_pkg;

  localparam int L2_NSTRMS_DEF    = 64;
  localparam int L2_TILES_DEF     = 4;
  localparam int L2_MAX_OUTST_DEF = 4;

  // Stream index width within a tile; never narrower than one bit.
  function automatic int sid_width(input int spt);
    return (spt <= 1) ? 1 : $clog2(spt);
  endfunction

  // Outstanding counter width; must be able to hold MAX_OUTST itself.
  function automatic int cnt_width(input int max_outst);
    return $clog2(max_outst + 1);
  endfunction

endpackage

// File: rtl/l2_tile_arb.sv
// One L2 tile: round-robin grant among its streams, credit-limited by an
// outstanding counter, one registered request slot, combinational response demux.
// Optional feature macro: L2_REQ_ARB_ERR_EN (adds err_o).
// Handshake rule: a transfer happens on a cycle where valid and ready are both 1;
// valid never depends on ready, and a presented request holds until accepted.
module l2_tile_arb
  import l2_arb_pkg::*;
#(
  parameter int SPT       = 16,
  parameter int MAX_OUTST = 4,
  localparam int SIDW     = sid_width(SPT),
  localparam int CNTW     = cnt_width(MAX_OUTST)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SPT-1:0]  req_v_i,
  output logic [SPT-1:0]  req_r_o,
  output logic            out_v_o,
  input  logic            out_r_i,
  output logic [SIDW-1:0] out_sid_o,
  input  logic            rsp_v_i,
  output logic            rsp_r_o,
  input  logic [SIDW-1:0] rsp_sid_i,
  output logic [SPT-1:0]  strm_rsp_v_o,
  input  logic [SPT-1:0]  strm_rsp_r_i
`ifdef L2_REQ_ARB_ERR_EN
  ,output logic           err_o
`endif
);

  localparam int SW1 = SIDW + 1;

  logic            out_v_q, out_v_d;
  logic [SIDW-1:0] out_sid_q, out_sid_d;
  logic [SPT-1:0]  pend_q, pend_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [SIDW-1:0] rr_q, rr_d;

  logic [SPT-1:0]  elig;
  logic            found;
  logic [SIDW-1:0] gnt_sid;
  logic [SW1-1:0]  idx_w;
  logic            rsp_hs, rsp_hit, slot_free, credit, grant;

  // Pick the first eligible stream at or after the RR pointer, wrapping.
  always_comb begin
    elig    = req_v_i & ~pend_q;
    found   = 1'b0;
    gnt_sid = '0;
    idx_w   = '0;
    for (int i = 0; i < SPT; i++) begin
      idx_w = {1'b0, rr_q} + SW1'(i);
      if (idx_w >= SW1'(SPT)) idx_w = idx_w - SW1'(SPT);
      if (!found && elig[idx_w[SIDW-1:0]]) begin
        found   = 1'b1;
        gnt_sid = idx_w[SIDW-1:0];
      end
    end
  end

  // A response returning a credit this cycle lets a grant proceed even when full.
  assign rsp_hs    = rsp_v_i & strm_rsp_r_i[rsp_sid_i];
  assign rsp_hit   = rsp_hs & pend_q[rsp_sid_i];
  assign slot_free = ~out_v_q | out_r_i;
  assign credit    = (cnt_q < CNTW'(MAX_OUTST)) | rsp_hit;
  assign grant     = slot_free & credit & found;
  assign rsp_r_o   = strm_rsp_r_i[rsp_sid_i];

  // One-hot request ready and response valid demux.
  always_comb begin
    req_r_o      = '0;
    strm_rsp_v_o = '0;
    for (int i = 0; i < SPT; i++) begin
      req_r_o[i]      = grant && (gnt_sid == SIDW'(i));
      strm_rsp_v_o[i] = rsp_v_i && (rsp_sid_i == SIDW'(i));
    end
  end

  // Next-state: output slot, pending vector, credit counter, RR pointer.
  always_comb begin
    out_v_d   = out_v_q;
    out_sid_d = out_sid_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    if (grant) begin
      out_v_d   = 1'b1;
      out_sid_d = gnt_sid;
    end else if (out_r_i) begin
      out_v_d = 1'b0;
    end
    if (rsp_hit) pend_d[rsp_sid_i] = 1'b0;
    if (grant)   pend_d[gnt_sid]   = 1'b1;
    if (grant && !rsp_hit)      cnt_d = cnt_q + CNTW'(1);
    else if (!grant && rsp_hit) cnt_d = cnt_q - CNTW'(1);
    if (grant) rr_d = (gnt_sid == SIDW'(SPT - 1)) ? '0 : gnt_sid + SIDW'(1);
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_v_q   <= 1'b0;
      out_sid_q <= '0;
      pend_q    <= '0;
      cnt_q     <= '0;
      rr_q      <= '0;
    end else begin
      out_v_q   <= out_v_d;
      out_sid_q <= out_sid_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
    end
  end

  assign out_v_o   = out_v_q;
  assign out_sid_o = out_sid_q;

`ifdef L2_REQ_ARB_ERR_EN
  logic err_q, err_d;
  // Sticky flag for a response to a stream with nothing pending.
  always_comb err_d = err_q | (rsp_hs & ~pend_q[rsp_sid_i]);
  // Error register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err_o = err_q;
`endif

endmodule

// File: rtl/l2_req_arb.sv
// L2 request arbiter top: splits NSTRMS streams into TILES independent tiles
// and instantiates one l2_tile_arb per tile.
// Optional feature macro: L2_REQ_ARB_ERR_EN (adds o_err).
module l2_req_arb
  import l2_arb_pkg::*;
#(
  parameter int NSTRMS    = L2_NSTRMS_DEF,
  parameter int TILES     = L2_TILES_DEF,
  parameter int MAX_OUTST = L2_MAX_OUTST_DEF,
  localparam int SPT      = NSTRMS / TILES,
  localparam int SIDW     = sid_width(SPT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSTRMS-1:0]     i_req_v,
  output logic [NSTRMS-1:0]     i_req_r,
  output logic [TILES-1:0]      o_tile_req_v,
  input  logic [TILES-1:0]      o_tile_req_r,
  output logic [TILES*SIDW-1:0] o_tile_req_sid,
  input  logic [TILES-1:0]      i_tile_rsp_v,
  output logic [TILES-1:0]      i_tile_rsp_r,
  input  logic [TILES*SIDW-1:0] i_tile_rsp_sid,
  output logic [NSTRMS-1:0]     o_rsp_v,
  input  logic [NSTRMS-1:0]     o_rsp_r
`ifdef L2_REQ_ARB_ERR_EN
  ,output logic [TILES-1:0]     o_err
`endif
);

  // Tile t owns streams t*SPT .. t*SPT+SPT-1.
  for (genvar t = 0; t < TILES; t++) begin : g_tile
    l2_tile_arb #(
      .SPT       (SPT),
      .MAX_OUTST (MAX_OUTST)
    ) u_tile (
      .clk          (clk),
      .reset        (reset),
      .req_v_i      (i_req_v[t*SPT +: SPT]),
      .req_r_o      (i_req_r[t*SPT +: SPT]),
      .out_v_o      (o_tile_req_v[t]),
      .out_r_i      (o_tile_req_r[t]),
      .out_sid_o    (o_tile_req_sid[t*SIDW +: SIDW]),
      .rsp_v_i      (i_tile_rsp_v[t]),
      .rsp_r_o      (i_tile_rsp_r[t]),
      .rsp_sid_i    (i_tile_rsp_sid[t*SIDW +: SIDW]),
      .strm_rsp_v_o (o_rsp_v[t*SPT +: SPT]),
      .strm_rsp_r_i (o_rsp_r[t*SPT +: SPT])
`ifdef L2_REQ_ARB_ERR_EN
      ,.err_o       (o_err[t])
`endif
    );
  end

endmodule

// File: tb/tb_l2_req_arb.sv
// Directed bench for l2_req_arb at default parameters (64 streams, 4 tiles,
// 16 streams per tile, 4 outstanding per tile).
module tb_l2_req_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] i_req_v;
  logic [63:0] i_req_r;
  logic [3:0]  o_tile_req_v;
  logic [3:0]  o_tile_req_r;
  logic [15:0] o_tile_req_sid;
  logic [3:0]  i_tile_rsp_v;
  logic [3:0]  i_tile_rsp_r;
  logic [15:0] i_tile_rsp_sid;
  logic [63:0] o_rsp_v;
  logic [63:0] o_rsp_r;
`ifdef L2_REQ_ARB_ERR_EN
  logic [3:0]  o_err;
`endif

  int total = 0;
  int bad   = 0;

  l2_req_arb dut (
    .clk            (clk),
    .reset          (reset),
    .i_req_v        (i_req_v),
    .i_req_r        (i_req_r),
    .o_tile_req_v   (o_tile_req_v),
    .o_tile_req_r   (o_tile_req_r),
    .o_tile_req_sid (o_tile_req_sid),
    .i_tile_rsp_v   (i_tile_rsp_v),
    .i_tile_rsp_r   (i_tile_rsp_r),
    .i_tile_rsp_sid (i_tile_rsp_sid),
    .o_rsp_v        (o_rsp_v),
    .o_rsp_r        (o_rsp_r)
`ifdef L2_REQ_ARB_ERR_EN
    ,.o_err         (o_err)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  task automatic clear_inputs();
    i_req_v        = '0;
    o_tile_req_r   = '0;
    i_tile_rsp_v   = '0;
    i_tile_rsp_sid = '0;
    o_rsp_r        = '0;
  endtask

  // Leaves the bench just after a negedge with reset released and state clear.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    reset   = 1'b0;
    i_req_v = '1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      total++;
      if (o_tile_req_v !== 4'h0) begin
        bad++;
        $display("FAIL reset_valid cyc%0d got=%h want=0", k, o_tile_req_v);
      end
    end
    total++;
    if (i_req_r !== 64'h0001_0001_0001_0001) begin
      bad++;
      $display("FAIL reset_ready got=%h want=0001000100010001", i_req_r);
    end
    reset = 1'b1;
    @(negedge clk); #1;
    total++;
    if (o_tile_req_v !== 4'hF || o_tile_req_sid !== 16'h0000) begin
      bad++;
      $display("FAIL first_grant v=%h sid=%h want v=f sid=0000", o_tile_req_v, o_tile_req_sid);
    end
    total++;
    if (i_req_r !== 64'h0) begin
      bad++;
      $display("FAIL full_slot_ready got=%h want=0", i_req_r);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_r;
    logic [3:0]  exp_sid;
    do_reset();
    i_req_v[2:0] = 3'b111;
    o_tile_req_r = 4'hF;
    o_rsp_r      = '1;
    for (int k = 0; k < 6; k++) begin
      if (k >= 1) begin
        i_tile_rsp_v[0]        = 1'b1;
        i_tile_rsp_sid[3:0]    = 4'((k - 1) % 3);
      end
      #1;
      exp_r = 16'(1 << (k % 3));
      total++;
      if (i_req_r[15:0] !== exp_r) begin
        bad++;
        $display("FAIL rr_grant cyc%0d got=%h want=%h", k, i_req_r[15:0], exp_r);
      end
      if (k >= 1) begin
        exp_sid = 4'((k - 1) % 3);
        total++;
        if (o_tile_req_sid[3:0] !== exp_sid || o_rsp_v[15:0] !== 16'(1 << ((k - 1) % 3))) begin
          bad++;
          $display("FAIL rr_sid cyc%0d sid=%h rsp=%h want sid=%h", k, o_tile_req_sid[3:0],
                   o_rsp_v[15:0], exp_sid);
        end
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_credit();
    int grants;
    do_reset();
    i_req_v[5:0] = 6'h3F;
    o_tile_req_r = 4'hF;
    o_rsp_r      = '1;
    grants = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      grants += $countones(i_req_r[15:0]);
      @(negedge clk);
    end
    total++;
    if (grants !== 4) begin
      bad++;
      $display("FAIL credit_grants got=%0d want=4", grants);
    end
    i_tile_rsp_v[0]     = 1'b1;
    i_tile_rsp_sid[3:0] = 4'd0;
    #1;
    total++;
    if (i_req_r[15:0] !== 16'h0010) begin
      bad++;
      $display("FAIL credit_return got=%h want=0010", i_req_r[15:0]);
    end
    @(negedge clk);
    i_tile_rsp_v = '0;
    #1;
    total++;
    if (o_tile_req_v[0] !== 1'b1 || o_tile_req_sid[3:0] !== 4'd4) begin
      bad++;
      $display("FAIL credit_sid v=%b sid=%h want v=1 sid=4", o_tile_req_v[0], o_tile_req_sid[3:0]);
    end
    grants = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      grants += $countones(i_req_r[15:0]);
      @(negedge clk);
    end
    total++;
    if (grants !== 0) begin
      bad++;
      $display("FAIL credit_extra got=%0d want=0", grants);
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    o_tile_req_r = 4'b1101;
    o_rsp_r      = '1;
    i_req_v[17]  = 1'b1;
    i_req_v[18]  = 1'b1;
    #1;
    total++;
    if (i_req_r[31:16] !== 16'h0002) begin
      bad++;
      $display("FAIL bp_grant got=%h want=0002", i_req_r[31:16]);
    end
    @(negedge clk);
    i_req_v[17] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (o_tile_req_v[1] !== 1'b1 || o_tile_req_sid[7:4] !== 4'd1 || i_req_r[31:16] !== 16'h0) begin
        bad++;
        $display("FAIL bp_hold cyc%0d v=%b sid=%h rdy=%h want v=1 sid=1 rdy=0", k,
                 o_tile_req_v[1], o_tile_req_sid[7:4], i_req_r[31:16]);
      end
      @(negedge clk);
    end
    o_tile_req_r[1] = 1'b1;
    #1;
    total++;
    if (i_req_r[31:16] !== 16'h0004) begin
      bad++;
      $display("FAIL bp_release got=%h want=0004", i_req_r[31:16]);
    end
    @(negedge clk);
    i_req_v[18] = 1'b0;
    #1;
    total++;
    if (o_tile_req_v[1] !== 1'b1 || o_tile_req_sid[7:4] !== 4'd2) begin
      bad++;
      $display("FAIL bp_next v=%b sid=%h want v=1 sid=2", o_tile_req_v[1], o_tile_req_sid[7:4]);
    end
    clear_inputs();
  endtask

  task automatic test_simultaneous();
    do_reset();
    o_tile_req_r  = 4'hF;
    o_rsp_r       = '1;
    i_req_v[36:32] = 5'h1F;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (i_req_r[47:32] !== 16'(1 << k)) begin
        bad++;
        $display("FAIL sim_fill cyc%0d got=%h want=%h", k, i_req_r[47:32], 16'(1 << k));
      end
      @(negedge clk);
    end
    i_tile_rsp_v[2]      = 1'b1;
    i_tile_rsp_sid[11:8] = 4'd0;
    #1;
    total++;
    if (i_req_r[47:32] !== 16'h0010 || o_rsp_v[32] !== 1'b1 || i_tile_rsp_r[2] !== 1'b1 ||
        o_tile_req_sid[11:8] !== 4'd3) begin
      bad++;
      $display("FAIL sim_both rdy=%h rspv=%b rspr=%b sid=%h want rdy=0010 rspv=1 rspr=1 sid=3",
               i_req_r[47:32], o_rsp_v[32], i_tile_rsp_r[2], o_tile_req_sid[11:8]);
    end
    @(negedge clk);
    i_tile_rsp_v = '0;
    #1;
    total++;
    if (o_tile_req_v[2] !== 1'b1 || o_tile_req_sid[11:8] !== 4'd4 || i_req_r[47:32] !== 16'h0) begin
      bad++;
      $display("FAIL sim_count v=%b sid=%h rdy=%h want v=1 sid=4 rdy=0", o_tile_req_v[2],
               o_tile_req_sid[11:8], i_req_r[47:32]);
    end
    @(negedge clk);
    i_tile_rsp_v[2]      = 1'b1;
    i_tile_rsp_sid[11:8] = 4'd1;
    #1;
    total++;
    if (i_req_r[47:32] !== 16'h0001) begin
      bad++;
      $display("FAIL sim_after got=%h want=0001", i_req_r[47:32]);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_stray_response();
    do_reset();
    i_tile_rsp_v[0]     = 1'b1;
    i_tile_rsp_sid[3:0] = 4'd5;
    #1;
    total++;
    if (o_rsp_v !== 64'h20 || i_tile_rsp_r[0] !== 1'b0) begin
      bad++;
      $display("FAIL stray_fwd rspv=%h rspr=%b want rspv=20 rspr=0", o_rsp_v, i_tile_rsp_r[0]);
    end
    o_rsp_r[5] = 1'b1;
    #1;
    total++;
    if (i_tile_rsp_r[0] !== 1'b1) begin
      bad++;
      $display("FAIL stray_ready got=%b want=1", i_tile_rsp_r[0]);
    end
`ifdef L2_REQ_ARB_ERR_EN
    total++;
    if (o_err !== 4'h0) begin
      bad++;
      $display("FAIL err_early got=%h want=0", o_err);
    end
`endif
    @(negedge clk);
    i_tile_rsp_v = '0;
    i_req_v[0]   = 1'b1;
    #1;
    total++;
    if (i_req_r[15:0] !== 16'h0001 || o_rsp_v !== 64'h0) begin
      bad++;
      $display("FAIL stray_state rdy=%h rspv=%h want rdy=0001 rspv=0", i_req_r[15:0], o_rsp_v);
    end
`ifdef L2_REQ_ARB_ERR_EN
    total++;
    if (o_err !== 4'h1) begin
      bad++;
      $display("FAIL err_set got=%h want=1", o_err);
    end
    @(negedge clk);
    #1;
    total++;
    if (o_err !== 4'h1) begin
      bad++;
      $display("FAIL err_sticky got=%h want=1", o_err);
    end
`endif
    clear_inputs();
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_credit();
    test_backpressure();
    test_simultaneous();
    test_stray_response();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
